// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - SPI mode-3 frame master with power-up wake pulse and periodic sensor poll.
// Host frames of 1..MAX_BYTES bytes; autonomous 2-byte poll frames drive poll_byte/alarm.
module spi_frame_master #(
  parameter int         CLK_DIV      = 2,
  parameter int         MAX_BYTES    = 4,
  parameter int         PWRUP_CYCLES = 93750,
  parameter int         POLL_PERIOD  = 1562500,
  parameter logic [7:0] POLL_CMD     = 8'hFA,
  parameter logic [7:0] THRESHOLD    = 8'h84
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   poll_en,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic [7:0]             poll_byte,
  output logic                   alarm,
  output logic                   sck,
  output logic                   mosi,
  output logic                   cs_n,
  input  logic                   miso
);

  localparam int W  = 8 * MAX_BYTES;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(PWRUP_CYCLES + 1);
  localparam int TW = $clog2(POLL_PERIOD + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PWR_LAST  = PW'(PWRUP_CYCLES - 1);
  localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [2:0]    MAX_LEN   = 3'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_WAKE,
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pwr_cnt;
  logic [TW-1:0] poll_timer;
  logic [DW-1:0] div_cnt;
  logic          phase;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [2:0]    last_byte;
  logic          is_poll;
  logic [W-1:0]  tx_buf;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_bytes [MAX_BYTES];
  logic [7:0]    poll_sr;

  logic       div_end, bit_end, last_bit, accept, poll_due, poll_go, hold_end;
  logic [2:0] nxt_byte;

  always_comb begin
    div_end  = (div_cnt == DIV_LAST);
    bit_end  = div_end && phase;
    last_bit = bit_end && (bit_idx == 3'd7) && (byte_idx == last_byte);
    accept   = (state == S_IDLE) && start && (tx_len != 3'd0);
    poll_due = (poll_timer == POLL_LAST);
    poll_go  = (state == S_IDLE) && !accept && poll_en && poll_due;
    hold_end = (state == S_HOLD) && div_end;
    nxt_byte = byte_idx + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_PWRUP;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_PWRUP: if (pwr_cnt == PWR_LAST) state_nx = S_WAKE;
      S_WAKE:  state_nx = S_IDLE;
      S_IDLE:  if (accept || poll_go) state_nx = S_SHIFT;
      S_SHIFT: if (last_bit) state_nx = S_HOLD;
      S_HOLD:  if (div_end) state_nx = S_IDLE;
      default: state_nx = S_PWRUP;
    endcase
  end

  // Pins are decoded straight from registered state so an async reset idles them at once.
  always_comb begin
    cs_n = 1'b1;
    sck  = 1'b1;
    mosi = 1'b1;
    busy = 1'b1;
    case (state)
      S_WAKE:  cs_n = 1'b0;
      S_IDLE:  busy = 1'b0;
      S_SHIFT: begin
        cs_n = 1'b0;
        sck  = phase;
        mosi = tx_sr[7];
      end
      S_HOLD: begin
        cs_n = 1'b0;
        mosi = tx_sr[7];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_cnt    <= '0;
      poll_timer <= '0;
    end else begin
      if (state == S_PWRUP) pwr_cnt <= pwr_cnt + 1'b1;
      // Timer freezes outside IDLE, so an expiry lost to a host frame is served right after it.
      if (!poll_en)                         poll_timer <= '0;
      else if (hold_end && is_poll)         poll_timer <= '0;
      else if (state == S_IDLE && !poll_due) poll_timer <= poll_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      last_byte <= '0;
      is_poll   <= 1'b0;
      tx_buf    <= '0;
      tx_sr     <= 8'hFF;
      poll_sr   <= '0;
      done      <= 1'b0;
      rx_data   <= '0;
      poll_byte <= '0;
      alarm     <= 1'b0;
      for (int k = 0; k < MAX_BYTES; k++) rx_bytes[k] <= '0;
    end else begin
      done <= 1'b0;
      if (accept || poll_go) begin
        div_cnt  <= '0;
        phase    <= 1'b0;
        bit_idx  <= '0;
        byte_idx <= '0;
        is_poll  <= poll_go;
        if (accept) begin
          tx_buf    <= tx_data;
          tx_sr     <= tx_data[7:0];
          last_byte <= (tx_len > MAX_LEN) ? (MAX_LEN - 3'd1) : (tx_len - 3'd1);
          for (int k = 0; k < MAX_BYTES; k++) rx_bytes[k] <= '0;
        end else begin
          tx_sr     <= POLL_CMD;
          last_byte <= 3'd1;
        end
      end else if (state == S_SHIFT) begin
        div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        if (div_end) phase <= !phase;
        if (div_end && !phase) begin
          poll_sr <= {poll_sr[6:0], miso};
          if (!is_poll)
            for (int k = 0; k < MAX_BYTES; k++)
              if (byte_idx == 3'(k)) rx_bytes[k][~bit_idx] <= miso;
        end
        if (bit_end && !last_bit) begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            byte_idx <= nxt_byte;
            // Poll read byte keeps mosi high.
            if (is_poll) tx_sr <= 8'hFF;
            else
              for (int k = 0; k < MAX_BYTES; k++)
                if (nxt_byte == 3'(k)) tx_sr <= tx_buf[8*k +: 8];
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b1};
          end
        end
      end else if (state == S_HOLD) begin
        div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        if (div_end) begin
          if (is_poll) begin
            poll_byte <= poll_sr;
            alarm     <= (poll_sr > THRESHOLD);
          end else begin
            done <= 1'b1;
            for (int k = 0; k < MAX_BYTES; k++) rx_data[8*k +: 8] <= rx_bytes[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - self-checking bench for spi_frame_master.
// Vector table plus scoreboard for host frames; hand sequences for power-up, poll, arbitration, reset.
module tb_spi_frame_master;

  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 4;
  localparam int PWRUP     = 16;
  localparam int PERIOD    = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        poll_en = 1'b0;
  logic [2:0]  tx_len = 3'd0;
  logic [31:0] tx_data = 32'd0;
  logic        miso;
  logic        busy, done, alarm, sck, mosi, cs_n;
  logic [31:0] rx_data;
  logic [7:0]  poll_byte;

  spi_frame_master #(
    .CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .PWRUP_CYCLES(PWRUP), .POLL_PERIOD(PERIOD),
    .POLL_CMD(8'hFA), .THRESHOLD(8'h84)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tx_len(tx_len), .tx_data(tx_data),
    .poll_en(poll_en), .busy(busy), .done(done), .rx_data(rx_data), .poll_byte(poll_byte),
    .alarm(alarm), .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  always #5 clk = ~clk;

  // Slave model: echo mosi, or shift resp out MSB first, advancing after each sck rise.
  logic        echo = 1'b1;
  logic [63:0] resp = 64'd0;
  logic [5:0]  sbit = 6'd0;
  logic [63:0] mosi_log = 64'd0;
  int          nbits = 0, cs_falls = 0, done_cnt = 0;

  assign miso = echo ? mosi : resp[~sbit];

  always @(negedge cs_n) begin
    sbit = 6'd0; mosi_log = 64'd0; nbits = 0; cs_falls++;
  end
  always @(posedge sck) if (cs_n === 1'b0) begin
    mosi_log = {mosi_log[62:0], mosi}; nbits++; sbit = sbit + 6'd1;
  end
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  len;
    logic [31:0] data;
    logic        echo;
    logic [63:0] resp;
    int          n;
    logic [31:0] mosi_exp;
    logic [31:0] rx_exp;
    int          lat;
  } vec_t;

  typedef struct {
    int          n;
    logic [63:0] mosi;
    logic [31:0] rx;
    logic [31:0] mask;
    int          lat;
  } exp_t;

  vec_t        vt[5];
  exp_t        sbq[$];
  logic [31:0] last_rx = 32'd0, last_mask = 32'd0;

  task automatic run_frame(input vec_t v);
    exp_t e;
    int cyc;
    bit got;
    logic [63:0] m64;
    echo = v.echo;
    resp = v.resp;
    e.n = v.n; e.mosi = 64'(v.mosi_exp); e.rx = v.rx_exp; e.lat = v.lat;
    m64 = (64'd1 << (8 * v.n)) - 64'd1;
    e.mask = m64[31:0];
    sbq.push_back(e);
    @(negedge clk);
    tx_len = v.len; tx_data = v.data; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 1000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start = 1'b0; tx_len = 3'($urandom); tx_data = $urandom;
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) check("done_timeout", 64'(cyc), 64'(v.lat));
    e = sbq.pop_front();
    check("latency", 64'(cyc), 64'(e.lat));
    check("rx_data", 64'(rx_data & e.mask), 64'(e.rx));
    check("mosi_bits", mosi_log & m64, e.mosi);
    check("bit_count", 64'(nbits), 64'(8 * e.n));
    last_rx = e.rx; last_mask = e.mask;
  endtask

  task automatic check_powerup();
    int cyc;
    @(negedge clk); rst = 1'b0;
    cyc = 0;
    while (cs_n === 1'b1 && cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    check("pwrup_len", 64'(cyc), 64'(PWRUP));
    check("wake_sck", 64'(sck), 64'd1);
    @(negedge clk);
    check("wake_1clk", 64'(cs_n), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic wait_poll(input int f0);
    int cyc = 0;
    while (cs_falls == f0 && cyc < 1000) begin @(negedge clk); cyc++; end
    while (cs_n !== 1'b1 && cyc < 1200) begin @(negedge clk); cyc++; end
    if (cyc >= 1000) check("poll_timeout", 64'(cyc), 64'd0);
  endtask

  initial begin
    int f0, d0, cyc;
    vt[0] = '{3'd2, 32'h0000C3A5, 1'b1, 64'd0, 2, 32'h0000A5C3, 32'h0000C3A5, 67};
    vt[1] = '{3'd1, 32'h0000005A, 1'b0, 64'h3C00_0000_0000_0000, 1, 32'h5A, 32'h3C, 35};
    vt[2] = '{3'd4, 32'h12345678, 1'b1, 64'd0, 4, 32'h78563412, 32'h12345678, 131};
    vt[3] = '{3'd6, 32'hDEADBEEF, 1'b0, 64'hA1B2C3D4_00000000, 4, 32'hEFBEADDE, 32'hD4C3B2A1, 131};
    vt[4] = '{3'd3, 32'h00F00F81, 1'b0, 64'hFF0080_0000000000, 3, 32'h00810FF0, 32'h008000FF, 99};

    #2;
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_sck", 64'(sck), 64'd1);
    check("rst_mosi", 64'(mosi), 64'd1);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rx", 64'(rx_data), 64'd0);
    check("rst_poll", 64'({alarm, poll_byte}), 64'd0);
    check_powerup();

    for (int i = 0; i < 5; i++) run_frame(vt[i]);

    // tx_len=0 is ignored
    echo = 1'b1;
    f0 = cs_falls;
    @(negedge clk); tx_len = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("len0_no_cs", 64'(cs_falls - f0), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);

    // start during a frame is dropped, not queued
    f0 = cs_falls; d0 = done_cnt;
    @(negedge clk); tx_len = 3'd1; tx_data = 32'h5A; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    tx_len = 3'd2; tx_data = 32'hFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check("busy_done_seen", 64'(done), 64'd1);
    @(negedge clk);
    check("done_width", 64'(done), 64'd0);
    repeat (100) @(negedge clk);
    check("ignored_start_cs", 64'(cs_falls - f0), 64'd1);
    check("ignored_start_done", 64'(done_cnt - d0), 64'd1);
    check("ignored_start_mosi", mosi_log, 64'h5A);
    last_rx = 32'h5A; last_mask = 32'hFF;

    // periodic poll, alarm above and at threshold
    poll_en = 1'b1; echo = 1'b0; resp = 64'h0085_0000_0000_0000;
    f0 = cs_falls; d0 = done_cnt;
    wait_poll(f0);
    check("poll_byte_85", 64'(poll_byte), 64'h85);
    check("alarm_85", 64'(alarm), 64'd1);
    check("poll_mosi", mosi_log, 64'hFAFF);
    check("poll_bits", 64'(nbits), 64'd16);
    check("poll_no_done", 64'(done_cnt - d0), 64'd0);
    check("poll_rx_kept", 64'(rx_data & last_mask), 64'(last_rx));
    resp = 64'h0084_0000_0000_0000;
    f0 = cs_falls;
    wait_poll(f0);
    check("poll_byte_84", 64'(poll_byte), 64'h84);
    check("alarm_84", 64'(alarm), 64'd0);

    // host start on the exact expiry cycle wins; poll follows one cycle after done
    repeat (PERIOD - 1) @(posedge clk);
    run_frame('{3'd1, 32'h3C, 1'b0, 64'h1190_0000_0000_0000, 1, 32'h3C, 32'h11, 35});
    f0 = cs_falls;
    @(negedge clk);
    check("poll_after_done", 64'(cs_n), 64'd0);
    wait_poll(f0 - 1);
    check("poll_byte_90", 64'(poll_byte), 64'h90);
    check("alarm_90", 64'(alarm), 64'd1);
    check("poll2_mosi", mosi_log, 64'hFAFF);
    poll_en = 1'b0;

    // async reset mid-frame
    echo = 1'b1;
    @(negedge clk); tx_len = 3'd4; tx_data = 32'hCAFEBABE; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_frame_cs", 64'(cs_n), 64'd0);
    rst = 1'b1;
    #1;
    check("abort_cs_n", 64'(cs_n), 64'd1);
    check("abort_sck", 64'(sck), 64'd1);
    check("abort_mosi", 64'(mosi), 64'd1);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_rx", 64'(rx_data), 64'd0);
    check_powerup();
    run_frame(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
